// File: rtl/lab62soc_multi_timer.sv
// Multi-channel Avalon-MM interval timer: CHANNELS down-counters, shared irq.
// Define LAB62_TIMER_WATCHDOG_EN to turn channel 0 into a watchdog driving resetrequest.

module lab62soc_multi_timer_ch #(
  parameter int COUNT_W        = 32,
  parameter int DEFAULT_PERIOD = 49999,
  parameter bit WDOG           = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [1:0]         reg_sel,
  input  logic [COUNT_W-1:0] wdata,
  output logic [COUNT_W-1:0] period_o,
  output logic [COUNT_W-1:0] snap_o,
  output logic               run_o,
  output logic               tout_o,
  output logic               ito_o,
  output logic               cont_o
);
  localparam logic [COUNT_W-1:0] RST_P = COUNT_W'(DEFAULT_PERIOD);
  localparam logic [COUNT_W-1:0] ONE   = COUNT_W'(1);

  logic [COUNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
  logic               run_q, run_d, tout_q, tout_d, ito_q, ito_d, cont_q, cont_d;
  logic               period_wr, event_hit;

  always_comb begin
    cnt_d     = cnt_q;
    period_d  = period_q;
    snap_d    = snap_q;
    run_d     = run_q;
    tout_d    = tout_q;
    ito_d     = ito_q;
    cont_d    = cont_q;
    period_wr = wr_en && (reg_sel == 2'd2);
    // A PERIOD write owns the counter this cycle: no decrement, no event.
    event_hit = run_q && (cnt_q == '0) && !period_wr;
    if (run_q && !period_wr) begin
      if (cnt_q == '0) begin
        cnt_d = period_q;
        if (!cont_q) run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
    if (wr_en) begin
      case (reg_sel)
        2'd0: tout_d = 1'b0;
        2'd1: begin
          ito_d  = wdata[0];
          cont_d = wdata[1];
          if (wdata[3]) begin
            if (!(WDOG && run_q)) run_d = 1'b0;
          end else if (wdata[2]) begin
            run_d = 1'b1;
          end
        end
        2'd2: begin
          period_d = wdata;
          cnt_d    = wdata;
        end
        default: snap_d = cnt_q;
      endcase
    end
    if (event_hit) tout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= RST_P;
      period_q <= RST_P;
      snap_q   <= '0;
      run_q    <= 1'b0;
      tout_q   <= 1'b0;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      snap_q   <= snap_d;
      run_q    <= run_d;
      tout_q   <= tout_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
    end
  end

  assign period_o = period_q;
  assign snap_o   = snap_q;
  assign run_o    = run_q;
  assign tout_o   = tout_q;
  assign ito_o    = ito_q;
  assign cont_o   = cont_q;
endmodule

module lab62soc_multi_timer #(
  parameter int CHANNELS       = 4,
  parameter int COUNT_W        = 32,
  parameter int DEFAULT_PERIOD = 49999,
  parameter int ADDR_W         = $clog2(CHANNELS) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic              resetrequest
);
`ifdef LAB62_TIMER_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  logic [CHANNELS-1:0][COUNT_W-1:0] period, snap;
  logic [CHANNELS-1:0]              run, tout, ito, cont;
  logic [ADDR_W+1:0]                addr_x;
  logic [ADDR_W-1:0]                ch_idx;
  logic                             wr;
  logic [31:0]                      readdata_q, readdata_d;

  // Widened so the channel field exists even when CHANNELS == 1.
  assign addr_x = {2'b00, address};
  assign ch_idx = addr_x[ADDR_W+1:2];
  assign wr     = chipselect && !write_n;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    lab62soc_multi_timer_ch #(
      .COUNT_W       (COUNT_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD),
      .WDOG          ((i == 0) && WDOG_EN)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr && (ch_idx == ADDR_W'(i))),
      .reg_sel (address[1:0]),
      .wdata   (writedata[COUNT_W-1:0]),
      .period_o(period[i]),
      .snap_o  (snap[i]),
      .run_o   (run[i]),
      .tout_o  (tout[i]),
      .ito_o   (ito[i]),
      .cont_o  (cont[i])
    );
  end

  if (COUNT_W < 32) begin : g_wd_unused
    logic unused_wd_hi;
    assign unused_wd_hi = ^writedata[31:COUNT_W];
  end

  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_idx == ADDR_W'(i)) begin
        case (address[1:0])
          2'd0:    readdata_d = {30'b0, run[i], tout[i]};
          2'd1:    readdata_d = {30'b0, cont[i], ito[i]};
          2'd2:    readdata_d = 32'(period[i]);
          default: readdata_d = 32'(snap[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |(tout & ito);

`ifdef LAB62_TIMER_WATCHDOG_EN
  // Rising TO on channel 0 (re)loads a 2-cycle reset pulse.
  logic       to0_dly_q, to0_dly_d;
  logic [1:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    to0_dly_d = tout[0];
    wd_cnt_d  = wd_cnt_q;
    if (tout[0] && !to0_dly_q)  wd_cnt_d = 2'd2;
    else if (wd_cnt_q != 2'd0) wd_cnt_d = wd_cnt_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to0_dly_q <= 1'b0;
      wd_cnt_q  <= 2'd0;
    end else begin
      to0_dly_q <= to0_dly_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  assign resetrequest = (wd_cnt_q != 2'd0);
`else
  assign resetrequest = 1'b0;
`endif
endmodule

// File: tb/tb_lab62soc_multi_timer.sv
// Scoreboard bench for lab62soc_multi_timer; watchdog checks follow LAB62_TIMER_WATCHDOG_EN.
module tb_lab62soc_multi_timer;
  localparam int CH = 5;
  localparam int CW = 32;
  localparam int DP = 49999;
  localparam int AW = $clog2(CH) + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          chipselect, write_n;
  logic [31:0]   writedata, readdata;
  logic          irq, resetrequest;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];

  always #5 clk = ~clk;

  lab62soc_multi_timer #(
    .CHANNELS(CH), .COUNT_W(CW), .DEFAULT_PERIOD(DP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .irq         (irq),
    .resetrequest(resetrequest)
  );

  function automatic logic [AW-1:0] A(input int ch, input int r);
    return AW'(ch * 4 + r);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    address = A(ch, r); writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] v);
    address = A(ch, r); chipselect = 1'b1; write_n = 1'b1;
    cyc();
    v = readdata;
    chipselect = 1'b0;
  endtask

  // Issue queued reads: scoreboard entries were pushed with the stimulus.
  task automatic drain(input int ch[$], input int r[$]);
    logic [31:0] v, e;
    string       n;
    for (int i = 0; i < ch.size(); i++) begin
      rd(ch[i], r[i], v);
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      n_tests++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL %s: got %0h exp %0h", n, v, e);
      end
    end
  endtask

  task automatic test_reset();
    int ch[$];
    int r[$];
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; writedata = '0; address = A(0, 2);
    repeat (3) cyc();
    n_tests++;
    if ({readdata, irq, resetrequest} !== 34'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%0h irq=%b rr=%b exp 0/0/0", readdata, irq, resetrequest);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        ch.push_back(c); r.push_back(k);
        exp_q.push_back(k == 2 ? 32'(DP) : 32'd0);
        nm_q.push_back($sformatf("reset_ch%0d_reg%0d", c, k));
      end
    drain(ch, r);
  endtask

  task automatic test_continuous();
    wr(1, 2, 9); wr(1, 1, 7);
    repeat (9) cyc();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ch1_irq_early: got %b exp 0", irq); end
    cyc();
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ch1_irq_rise: got %b exp 1", irq); end
    wr(1, 0, 0);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ch1_irq_clear: got %b exp 0", irq); end
    repeat (8) cyc();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ch1_irq_gap: got %b exp 0", irq); end
    cyc();
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ch1_irq_second: got %b exp 1", irq); end
    exp_q.push_back(32'd3); nm_q.push_back("ch1_status_run_to");
    drain('{1}, '{0});
    wr(1, 1, 32'h8); wr(1, 0, 0);
  endtask

  task automatic test_oneshot();
    wr(2, 2, 4); wr(2, 1, 5);
    repeat (4) cyc();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ch2_irq_early: got %b exp 0", irq); end
    cyc();
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ch2_irq_rise: got %b exp 1", irq); end
    exp_q.push_back(32'd1); nm_q.push_back("ch2_status_oneshot");
    drain('{2}, '{0});
    wr(2, 3, 0);
    exp_q.push_back(32'd4); nm_q.push_back("ch2_snap_held");
    drain('{2}, '{3});
    wr(2, 0, 0);
    repeat (10) cyc();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ch2_no_rearm: got %b exp 0", irq); end
    wr(2, 1, 32'hD);
    repeat (6) cyc();
    exp_q.push_back(32'd0); nm_q.push_back("ch2_stop_wins");
    drain('{2}, '{0});
    wr(2, 1, 0);
  endtask

  task automatic test_snap_period();
    wr(3, 2, 100); wr(3, 1, 5);
    repeat (20) cyc();
    wr(3, 3, 0);
    exp_q.push_back(32'd80); nm_q.push_back("ch3_snap");
    drain('{3}, '{3});
    wr(3, 2, 5);
    repeat (5) cyc();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ch3_reload_early: got %b exp 0", irq); end
    wr(3, 0, 0);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ch3_event_wins: got %b exp 1", irq); end
    exp_q.push_back(32'd1); nm_q.push_back("ch3_status_event_wins");
    exp_q.push_back(32'd5); nm_q.push_back("ch3_period");
    drain('{3, 3}, '{0, 2});
    wr(3, 0, 0); wr(3, 1, 0);
  endtask

  task automatic test_out_of_range();
    wr(5, 2, 123); wr(5, 1, 5); wr(5, 3, 0); wr(7, 1, 7);
    repeat (3) cyc();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'd0); nm_q.push_back($sformatf("oob_ch5_reg%0d", k));
    end
    exp_q.push_back(32'd9); nm_q.push_back("oob_ch1_period");
    exp_q.push_back(32'd0); nm_q.push_back("oob_ch1_control");
    exp_q.push_back(32'd0); nm_q.push_back("oob_ch1_status");
    drain('{5, 5, 5, 5, 1, 1, 1}, '{0, 1, 2, 3, 2, 1, 0});
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oob_irq: got %b exp 0", irq); end
  endtask

  task automatic test_ch0();
    logic exp_rr;
    wr(0, 2, 3); wr(0, 1, 7);
`ifdef LAB62_TIMER_WATCHDOG_EN
    wr(0, 1, 32'hB);
    exp_q.push_back(32'd2); nm_q.push_back("wd_stop_ignored");
    drain('{0}, '{0});
    for (int k = 3; k <= 16; k++) begin
      if (k == 7 || k == 11) begin
        address = A(0, 0); writedata = '0; chipselect = 1'b1; write_n = 1'b0;
      end else begin
        chipselect = 1'b0; write_n = 1'b1;
      end
      cyc();
      exp_rr = (k == 5 || k == 6 || k == 9 || k == 10 || k == 13 || k == 14);
      n_tests++;
      if (resetrequest !== exp_rr) begin
        n_fail++;
        $display("FAIL wd_resetrequest_k%0d: got %b exp %b", k, resetrequest, exp_rr);
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
`else
    wr(0, 1, 32'h8);
    exp_q.push_back(32'd0); nm_q.push_back("ch0_stop_halts");
    drain('{0}, '{0});
    exp_rr = 1'b0;
    for (int k = 3; k <= 16; k++) begin
      cyc();
      n_tests++;
      if (resetrequest !== exp_rr) begin
        n_fail++;
        $display("FAIL rr_tied_k%0d: got %b exp 0", k, resetrequest);
      end
    end
    exp_q.push_back(32'd0); nm_q.push_back("ch0_still_stopped");
    drain('{0}, '{0});
`endif
  endtask

  task automatic test_reset_mid();
    wr(1, 2, 20); wr(1, 1, 7);
    repeat (5) cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    n_tests++;
    if (irq !== 1'b0 || resetrequest !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got irq=%b rr=%b exp 0/0", irq, resetrequest);
    end
    exp_q.push_back(32'd0);      nm_q.push_back("midreset_ch0_status");
    exp_q.push_back(32'd0);      nm_q.push_back("midreset_ch1_status");
    exp_q.push_back(32'(DP));    nm_q.push_back("midreset_ch1_period");
    exp_q.push_back(32'd0);      nm_q.push_back("midreset_ch1_control");
    exp_q.push_back(32'(DP));    nm_q.push_back("midreset_ch0_period");
    drain('{0, 1, 1, 1, 0}, '{0, 0, 2, 1, 2});
    repeat (25) cyc();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_idle_irq: got %b exp 0", irq); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_oneshot();
    test_snap_period();
    test_out_of_range();
    test_ch0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lab62soc_multi_timer.md
# lab62soc_multi_timer

Parametrised multi-channel interval timer on the lab62soc Avalon-MM bus, the successor to the single fixed-period timer. Provides CHANNELS independent down-counters of COUNT_W bits, each with a software-writable period, one-shot or continuous mode, start/stop control, a snapshot register and a maskable timeout interrupt. All channel interrupts combine onto one irq line. An optional watchdog mode on channel 0 drives resetrequest.

## Interface
- CHANNELS, 4, number of timer channels (1–8)
- COUNT_W, 32, counter/period width in bits (8–32)
- DEFAULT_PERIOD, 49999, reset value of every period register and counter (fits COUNT_W)
- ADDR_W, $clog2(CHANNELS)+2, derived; do not override
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- address  in  ADDR_W  word address; upper bits = channel, lower 2 bits = register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data; bits above COUNT_W ignored
- readdata  out  32  registered read data; bits above COUNT_W read 0
- irq  out  1  OR over channels of (TO & ITO)
- resetrequest  out  1  watchdog reset pulse (see Configuration)

## Operation
- Per-channel registers (low address bits):
  - 0 STATUS: read {30'b0, RUN, TO}; any write clears TO.
  - 1 CONTROL: bit0 ITO (irq enable), bit1 CONT (continuous); bit2 START, bit3 STOP are write-only strobes, read 0.
  - 2 PERIOD: write sets period and forces counter reload; read returns period.
  - 3 SNAP: write captures current counter; read returns last snapshot.
- Address with channel index ≥ CHANNELS: writes ignored, reads return 0.
- Counter, when RUN: if counter==0, timeout event; counter reloads period; if CONT=0, RUN clears. Otherwise counter decrements by 1. Period P gives one event every P+1 cycles.
- Timeout event sets TO (sticky until STATUS write).
- Counter holds its value while RUN=0; START resumes from held value.
- START and STOP in same write: STOP wins.
- STATUS write coinciding with timeout event: TO set (event wins).
- PERIOD write: counter loads new value next edge whatever RUN; no timeout event that cycle; RUN unchanged.
- PERIOD=0 with CONT=1: timeout event every cycle while running.
- Channels fully independent; no cross-channel priority.

## Timing
- Reset values: readdata 0, irq 0, resetrequest 0; per channel counter=period=DEFAULT_PERIOD, snapshot 0, RUN 0, TO 0, ITO 0, CONT 0.
- Reset asserted mid-count returns all state to reset values at the next edge.
- Writes take effect at the clock edge on which chipselect & ~write_n is sampled.
- Read latency 1: readdata at edge N+1 reflects registers as of edge N for address at edge N; readdata updates every cycle.
- TO and RUN (one-shot) update at the edge after the cycle with counter==0 & RUN.
- irq is combinational from TO/ITO registers: rises the cycle after the timeout event; falls the cycle after a STATUS write or ITO clear.
- START at edge N: first decrement at edge N+1.

## Configuration
- LAB62_TIMER_WATCHDOG_EN defined: channel 0 is a watchdog — STOP on channel 0 ignored once RUN set (only reset clears it); a rising edge of channel 0 TO drives resetrequest high for exactly 2 cycles beginning the cycle after TO rises; a new rising edge during the pulse restarts the 2-cycle count.
- Not defined: resetrequest tied 0; channel 0 behaves like all other channels.

## Test plan
- Reset, read every register of channels 0–3 -> PERIOD and SNAP = 49999 and 0, STATUS/CONTROL = 0, irq=0, resetrequest=0.
- Ch1: PERIOD=9, CONTROL=0x7 (ITO, CONT, START) -> TO/irq rise every 10 cycles; STATUS write clears irq the next cycle; counter keeps running.
- Ch2 one-shot: PERIOD=4, CONTROL=0x5 -> one event after 5 cycles, RUN reads 0, counter holds at 4; STOP+START in the same write -> RUN stays 0.
- Ch3: PERIOD=100, start, SNAP write after 20 cycles -> SNAP reads 80; PERIOD=5 write mid-count -> next event 6 cycles later; STATUS write on the event cycle -> TO still reads 1.
- Write to channel index 5 with CHANNELS=4 -> no state change, reads return 0.
- With LAB62_TIMER_WATCHDOG_EN: ch0 PERIOD=3, start, STOP written -> RUN stays 1; resetrequest high exactly 2 cycles after each TO rise (clear TO between events). Without the macro -> resetrequest constantly 0 and STOP halts ch0.
